// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment encodings and sizing helper for the 7-segment display blocks
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; entry k encodes BCD digit k
    localparam logic [9:0][6:0] SEG_CODES = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low 7-segment pattern; non-BCD codes go dark
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = (bcd > 4'd9) ? SEG_BLANK : SEG_CODES[bcd];

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed common-anode 7-segment driver with frame-synchronous
// digit updates, leading-zero blanking and per-digit decimal points
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digit_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW = clog2(NUM_DIGITS);
    localparam int CW = clog2(REFRESH_DIV);

    logic [CW-1:0]                cnt;
    logic [IW-1:0]                idx;
    logic [NUM_DIGITS-1:0][3:0]   act_dig, pend_dig;
    logic [NUM_DIGITS-1:0]        act_dp, pend_dp;
    logic                         pend_valid;
    logic                         tick, boundary, blank;
    logic [6:0]                   cur_seg;

    assign tick     = enable && (cnt == CW'(REFRESH_DIV - 1));
    assign boundary = tick && (idx == IW'(NUM_DIGITS - 1));
    // Current digit and everything above it are zero when the shifted-down value is zero
    assign blank    = blank_lz && (idx != '0) && ((act_dig >> {idx, 2'b00}) == '0);

    seg7_decode u_dec (
        .bcd (act_dig[idx]),
        .seg (cur_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
            act_dig    <= '0;
            act_dp     <= '0;
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (enable) cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) idx <= boundary ? '0 : idx + IW'(1);
            frame_done <= boundary;
            if (load && !boundary) begin
                pend_dig <= digit_in;
                pend_dp  <= dp_in;
            end
            pend_valid <= boundary ? 1'b0 : (load || pend_valid);
            // A load landing on the boundary bypasses pending so the newest value wins
            if (boundary && (load || pend_valid)) begin
                act_dig <= load ? digit_in : pend_dig;
                act_dp  <= load ? dp_in : pend_dp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= (enable && !blank) ? cur_seg : SEG_BLANK;
            dp  <= ~(enable && act_dp[idx]);
            an  <= enable ? ~(NUM_DIGITS'(1) << idx) : '1;
        end
    end

endmodule
